// File: rtl/csr_pkg.sv
// Shared CSR constants: Zicsr funct3 encodings, sequencer states, trap target addresses.
// is_read_only() marks CSRs whose address top bits are 2'b11.
package csr_pkg;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    localparam logic [CSR_AW-1:0] MEPC_ADDR   = 12'h341;
    localparam logic [CSR_AW-1:0] MCAUSE_ADDR = 12'h342;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_TRAP_EPC,
        ST_TRAP_CAUSE
    } state_t;

    function automatic logic is_read_only(input logic [CSR_AW-1:0] addr);
        return addr[CSR_AW-1 -: 2] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational Zicsr decode: new CSR value, write qualification and illegal detection.
// Immediate variants share the register variants' operation; funct3[1:0] selects it.
module csr_alu
    import csr_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [CSR_AW-1:0] addr_i,
    input  logic [W-1:0]      old_i,
    input  logic [W-1:0]      src_i,
    input  logic              src_nz_i,
    output logic [W-1:0]      new_o,
    output logic              do_write_o,
    output logic              illegal_o
);

    logic want_write;
    logic bad_f3;

    always_comb begin
        new_o      = old_i;
        want_write = 1'b0;
        bad_f3     = 1'b0;
        unique case (funct3_i[1:0])
            2'b01: begin
                new_o      = src_i;
                want_write = 1'b1;
            end
            2'b10: begin
                new_o      = old_i | src_i;
                want_write = src_nz_i;
            end
            2'b11: begin
                new_o      = old_i & ~src_i;
                want_write = src_nz_i;
            end
            default: bad_f3 = 1'b1;
        endcase
    end

    // Reading a read-only CSR is fine; only an actual write attempt faults.
    assign illegal_o  = bad_f3 | (want_write & is_read_only(addr_i));
    assign do_write_o = want_write & ~illegal_o;

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences Zicsr read-modify-write and trap-entry mepc/mcause updates onto one CSR port.
// Request: 3 cycles (accept, READ, WRITE); trap: 3 cycles. Traps win in IDLE; req_ready=0 outside IDLE.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int                   XLEN_P      = XLEN,
    parameter logic [CSR_AW-1:0]    MEPC_A      = MEPC_ADDR,
    parameter logic [CSR_AW-1:0]    MCAUSE_A    = MCAUSE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [CSR_AW-1:0] req_addr,
    input  logic [XLEN_P-1:0] req_src,
    input  logic              req_src_nz,
    output logic              rsp_valid,
    output logic [XLEN_P-1:0] rsp_rdata,
    output logic              rsp_illegal,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic [XLEN_P-1:0] trap_pc,
    input  logic [XLEN_P-1:0] trap_cause,
    output logic [CSR_AW-1:0] csr_addr,
    input  logic [XLEN_P-1:0] csr_rdata,
    output logic              csr_we,
    output logic [XLEN_P-1:0] csr_wdata
);

    state_t              state_q;
    logic [2:0]          funct3_q;
    logic [XLEN_P-1:0]   src_q;
    logic                src_nz_q;
    logic [XLEN_P-1:0]   old_q;
    logic [CSR_AW-1:0]   addr_q;
    logic [XLEN_P-1:0]   wdata_q;
    logic                we_q;
    logic                rsp_valid_q;
    logic                rsp_illegal_q;
    logic                trap_ready_q;

    logic [XLEN_P-1:0]   alu_new;
    logic                alu_do_write;
    logic                alu_illegal;

    csr_alu #(.W(XLEN_P)) u_alu (
        .funct3_i   (funct3_q),
        .addr_i     (addr_q),
        .old_i      (csr_rdata),
        .src_i      (src_q),
        .src_nz_i   (src_nz_q),
        .new_o      (alu_new),
        .do_write_o (alu_do_write),
        .illegal_o  (alu_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            funct3_q      <= '0;
            src_q         <= '0;
            src_nz_q      <= 1'b0;
            old_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            trap_ready_q  <= 1'b0;
        end else begin
            we_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            trap_ready_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (trap_valid) begin
                        addr_q  <= MEPC_A;
                        wdata_q <= trap_pc;
                        we_q    <= 1'b1;
                        state_q <= ST_TRAP_EPC;
                    end else if (req_valid) begin
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        src_q    <= req_src;
                        src_nz_q <= req_src_nz;
                        state_q  <= ST_READ;
                    end
                end
                // Write-cycle outputs are registered here so WRITE drives them straight from flops.
                ST_READ: begin
                    old_q         <= alu_illegal ? '0 : csr_rdata;
                    we_q          <= alu_do_write;
                    if (alu_do_write) wdata_q <= alu_new;
                    rsp_valid_q   <= 1'b1;
                    rsp_illegal_q <= alu_illegal;
                    state_q       <= ST_WRITE;
                end
                ST_WRITE: state_q <= ST_IDLE;
                ST_TRAP_EPC: begin
                    addr_q       <= MCAUSE_A;
                    wdata_q      <= trap_cause;
                    we_q         <= 1'b1;
                    trap_ready_q <= 1'b1;
                    state_q      <= ST_TRAP_CAUSE;
                end
                ST_TRAP_CAUSE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // rst masks the in-flight cycle so a mid-operation reset leaves no side effects.
    assign req_ready   = (state_q == ST_IDLE) & ~trap_valid & ~rst;
    assign csr_we      = we_q & ~rst;
    assign rsp_valid   = rsp_valid_q & ~rst;
    assign trap_ready  = trap_ready_q & ~rst;
    assign rsp_illegal = rsp_illegal_q;
    assign rsp_rdata   = old_q;
    assign csr_addr    = addr_q;
    assign csr_wdata   = wdata_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural CSR register file.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_src_nz;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic        trap_valid;
    logic        trap_ready;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [31:0] csr_wdata;

    always #5 clk = ~clk;

    csr_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_src(req_src), .req_src_nz(req_src_nz),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .trap_pc(trap_pc), .trap_cause(trap_cause),
        .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wdata(csr_wdata)
    );

    // Register file model: combinational read, synchronous write, plus a preload port.
    logic [31:0] mem [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_dat;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_dat;
        else if (csr_we) mem[csr_addr] <= csr_wdata;
    end
    assign csr_rdata = mem[csr_addr];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [11:0] a,
                             input logic [31:0] s, input logic nz);
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_src = s; req_src_nz = nz;
    endtask

    // Waits (bounded) for req_ready, then crosses the accept edge; returns in READ.
    task automatic accept(input string nm);
        int b = 0;
        #1;
        while (!req_ready && b < 8) begin
            tick();
            b++;
        end
        chk({nm, "_accept_ready"}, {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] old;
        logic [31:0] src;
        logic        nz;
        logic [31:0] exp_rd;
        logic        exp_ill;
        logic        exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vt [11];

    initial begin
        vt[0]  = '{3'b001, 12'h300, 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vt[1]  = '{3'b010, 12'h300, 32'h0000_000F, 32'h0000_00F0, 1'b1, 32'h0000_000F, 1'b0, 1'b1, 32'h0000_00FF};
        vt[2]  = '{3'b010, 12'h300, 32'h0000_000F, 32'h0000_00F0, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{3'b011, 12'h304, 32'h0000_0003, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002};
        vt[4]  = '{3'b100, 12'h304, 32'h0000_0003, 32'h0000_0001, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};
        vt[5]  = '{3'b001, 12'hC00, 32'h0000_1234, 32'h0000_0005, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};
        vt[6]  = '{3'b010, 12'hC00, 32'h0000_1234, 32'h0000_0000, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{3'b101, 12'h305, 32'h0000_0000, 32'h0000_001F, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0000_001F};
        vt[8]  = '{3'b111, 12'h300, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFEF};
        vt[9]  = '{3'b000, 12'h300, 32'h0000_0055, 32'h0000_0001, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};
        vt[10] = '{3'b110, 12'hC01, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_src = '0; req_src_nz = 1'b0;
        trap_valid = 1'b0; trap_pc = '0; trap_cause = '0;
        pl_en = 1'b0; pl_addr = '0; pl_dat = '0;

        tick(); tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
        chk("rst_trap_ready", {31'd0, trap_ready}, 32'd0);
        chk("rst_csr_we", {31'd0, csr_we}, 32'd0);
        chk("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
        chk("rst_csr_wdata", csr_wdata, 32'd0);

        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            preload(vt[i].addr, vt[i].old);
            drive_req(vt[i].f3, vt[i].addr, vt[i].src, vt[i].nz);
            accept(nm);
            chk({nm, "_read_req_ready"}, {31'd0, req_ready}, 32'd0);
            chk({nm, "_read_we"}, {31'd0, csr_we}, 32'd0);
            chk({nm, "_read_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
            tick();
            chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({nm, "_rsp_rdata"}, rsp_rdata, vt[i].exp_rd);
            chk({nm, "_rsp_illegal"}, {31'd0, rsp_illegal}, {31'd0, vt[i].exp_ill});
            chk({nm, "_csr_we"}, {31'd0, csr_we}, {31'd0, vt[i].exp_we});
            chk({nm, "_csr_addr"}, {20'd0, csr_addr}, {20'd0, vt[i].addr});
            if (vt[i].exp_we) chk({nm, "_csr_wdata"}, csr_wdata, vt[i].exp_wd);
            tick();
            chk({nm, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
            chk({nm, "_mem"}, mem[vt[i].addr], vt[i].exp_we ? vt[i].exp_wd : vt[i].old);
        end

        // Trap and request together: trap first, request in the following IDLE cycle.
        preload(12'h300, 32'h0000_0077);
        drive_req(3'b001, 12'h300, 32'h0000_00AA, 1'b1);
        trap_valid = 1'b1; trap_pc = 32'h8000_0010; trap_cause = 32'h0000_000B;
        #1;
        chk("trap_req_blocked", {31'd0, req_ready}, 32'd0);
        tick();
        chk("epc_we", {31'd0, csr_we}, 32'd1);
        chk("epc_addr", {20'd0, csr_addr}, 32'h341);
        chk("epc_wdata", csr_wdata, 32'h8000_0010);
        chk("epc_req_ready", {31'd0, req_ready}, 32'd0);
        chk("epc_trap_ready", {31'd0, trap_ready}, 32'd0);
        tick();
        chk("cause_we", {31'd0, csr_we}, 32'd1);
        chk("cause_addr", {20'd0, csr_addr}, 32'h342);
        chk("cause_wdata", csr_wdata, 32'h0000_000B);
        chk("cause_trap_ready", {31'd0, trap_ready}, 32'd1);
        trap_valid = 1'b0;
        tick();
        chk("trap_done_pulse", {31'd0, trap_ready}, 32'd0);
        chk("mem_mepc", mem[12'h341], 32'h8000_0010);
        chk("mem_mcause", mem[12'h342], 32'h0000_000B);
        accept("post_trap");
        tick();
        chk("post_trap_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_trap_rsp_rdata", rsp_rdata, 32'h0000_0077);
        chk("post_trap_wdata", csr_wdata, 32'h0000_00AA);
        tick();

        // Reset during READ.
        preload(12'h300, 32'h0000_0011);
        drive_req(3'b001, 12'h300, 32'h0000_0022, 1'b1);
        accept("rstrd");
        rst = 1'b1;
        #1;
        chk("rstrd_we", {31'd0, csr_we}, 32'd0);
        chk("rstrd_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstrd_idle_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("rstrd_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rstrd_no_we", {31'd0, csr_we}, 32'd0);
        tick();
        chk("rstrd_mem", mem[12'h300], 32'h0000_0011);

        // Reset during WRITE: write and response are suppressed.
        drive_req(3'b001, 12'h300, 32'h0000_0033, 1'b1);
        accept("rstwr");
        tick();
        rst = 1'b1;
        #1;
        chk("rstwr_we", {31'd0, csr_we}, 32'd0);
        chk("rstwr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstwr_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("rstwr_mem", mem[12'h300], 32'h0000_0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
